// File: rtl/full_sub_cell.sv
// One-bit structural full subtractor: d = a - b - bin, bout is the borrow out.
// Built from gate primitives so it maps one-to-one onto the cell library.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    wire a_n;
    wire ab_x;
    wire ab_xn;
    wire brw_gen;
    wire brw_prop;

    not u_not_a   (a_n, a);
    xor u_xor_ab  (ab_x, a, b);
    xor u_xor_d   (d, ab_x, bin);
    not u_not_ab  (ab_xn, ab_x);

    // Borrow is generated when a=0,b=1; an incoming borrow passes through when a==b.
    and u_and_gen (brw_gen, a_n, b);
    and u_and_prp (brw_prop, ab_xn, bin);
    or  u_or_bout (bout, brw_gen, brw_prop);

endmodule

// File: rtl/full_sub_ugp.sv
// Ripple-borrow subtractor: {y, x} = a - b - c, with a registered copy (x_q, y_q)
// for pipelined datapaths. The combinational outputs carry no state and ignore rst.
module full_sub_ugp #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] x,
    output logic             y,
    output logic [WIDTH-1:0] x_q,
    output logic             y_q
);

    localparam logic [WIDTH-1:0] X_RST = '0;
    localparam logic             Y_RST = 1'b0;

    wire [WIDTH:0]   borrow;
    wire [WIDTH-1:0] diff;

    assign borrow[0] = c;

    // Borrow chain runs LSB to MSB; the last borrow-out is the overall borrow.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_sub_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (borrow[i]),
            .d    (diff[i]),
            .bout (borrow[i+1])
        );
    end

    assign x = diff;
    assign y = borrow[WIDTH];

    // Output register stage: reset takes priority over the data load.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= X_RST;
            y_q <= Y_RST;
        end else begin
            x_q <= x;
            y_q <= y;
        end
    end

endmodule

// File: tb/tb_full_sub_ugp.sv
// Directed and random checks of full_sub_ugp at WIDTH 1, 4 and 8.
module tb_full_sub_ugp;

    logic       clk;
    logic       rst;

    logic       a1, b1, c1;
    logic       x1, y1, xq1, yq1;

    logic [3:0] a4, b4;
    logic       c4;
    logic [3:0] x4, xq4;
    logic       y4, yq4;

    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] x8, xq8;
    logic       y8, yq8;

    int tests;
    int fails;

    full_sub_ugp #(.WIDTH(1)) dut1 (
        .clk (clk), .rst (rst), .a (a1), .b (b1), .c (c1),
        .x (x1), .y (y1), .x_q (xq1), .y_q (yq1)
    );

    full_sub_ugp #(.WIDTH(4)) dut4 (
        .clk (clk), .rst (rst), .a (a4), .b (b4), .c (c4),
        .x (x4), .y (y4), .x_q (xq4), .y_q (yq4)
    );

    full_sub_ugp #(.WIDTH(8)) dut8 (
        .clk (clk), .rst (rst), .a (a8), .b (b8), .c (c8),
        .x (x8), .y (y8), .x_q (xq8), .y_q (yq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic a;
        logic b;
        logic c;
        logic x;
        logic y;
    } vec1_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [3:0] x;
        logic       y;
    } vec4_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec1_t tt1 [8];
        vec4_t tt4 [6];
        logic [8:0] model;
        logic [8:0] model_prev;

        tests = 0;
        fails = 0;

        tt1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tt1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tt1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tt1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tt1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tt1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tt1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tt1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        tt4[0] = '{4'h3, 4'h5, 1'b0, 4'hE, 1'b1};
        tt4[1] = '{4'h9, 4'h4, 1'b1, 4'h4, 1'b0};
        tt4[2] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b1};
        tt4[3] = '{4'hF, 4'h0, 1'b0, 4'hF, 1'b0};
        tt4[4] = '{4'h8, 4'h7, 1'b1, 4'h0, 1'b0};
        tt4[5] = '{4'h8, 4'h8, 1'b1, 4'hF, 1'b1};

        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
        a8 = 8'h0; b8 = 8'h0; c8 = 1'b0;

        // Reset state of every registered output.
        @(posedge clk); #1;
        chk("rst_xq1", 32'(xq1), 32'(1'b0));
        chk("rst_yq1", 32'(yq1), 32'(1'b0));
        chk("rst_xq4", 32'(xq4), 32'(4'h0));
        chk("rst_xq8", 32'(xq8), 32'(8'h0));
        chk("rst_yq8", 32'(yq8), 32'(1'b0));

        @(negedge clk);
        rst = 1'b0;

        // WIDTH=1 exhaustive truth table.
        for (int i = 0; i < 8; i++) begin
            a1 = tt1[i].a; b1 = tt1[i].b; c1 = tt1[i].c;
            #1;
            chk($sformatf("tt1_x[%0d]", i), 32'(x1), 32'(tt1[i].x));
            chk($sformatf("tt1_y[%0d]", i), 32'(y1), 32'(tt1[i].y));
            @(negedge clk);
        end

        // Registered path: settle to 0/0, then load 1/0 on one edge.
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        @(posedge clk); #1;
        chk("reg_pre_xq", 32'(xq1), 32'(1'b0));
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        #1;
        chk("reg_before_edge_xq", 32'(xq1), 32'(1'b0));
        chk("reg_before_edge_yq", 32'(yq1), 32'(1'b0));
        @(posedge clk); #1;
        chk("reg_after_edge_xq", 32'(xq1), 32'(1'b1));
        chk("reg_after_edge_yq", 32'(yq1), 32'(1'b0));

        // Reset mid-operation with x=1,y=1 held on the inputs.
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
        rst = 1'b1;
        for (int e = 0; e < 2; e++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_hold_xq[%0d]", e), 32'(xq1), 32'(1'b0));
            chk($sformatf("rst_hold_yq[%0d]", e), 32'(yq1), 32'(1'b0));
            chk($sformatf("rst_hold_x[%0d]", e), 32'(x1), 32'(1'b1));
            chk($sformatf("rst_hold_y[%0d]", e), 32'(y1), 32'(1'b1));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_pre_xq", 32'(xq1), 32'(1'b0));
        @(posedge clk); #1;
        chk("rst_release_xq", 32'(xq1), 32'(1'b1));
        chk("rst_release_yq", 32'(yq1), 32'(1'b1));

        // WIDTH=4 ripple and wrap vectors, plus their registered copies.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a4 = tt4[i].a; b4 = tt4[i].b; c4 = tt4[i].c;
            #1;
            chk($sformatf("tt4_x[%0d]", i), 32'(x4), 32'(tt4[i].x));
            chk($sformatf("tt4_y[%0d]", i), 32'(y4), 32'(tt4[i].y));
            @(posedge clk); #1;
            chk($sformatf("tt4_xq[%0d]", i), 32'(xq4), 32'(tt4[i].x));
            chk($sformatf("tt4_yq[%0d]", i), 32'(yq4), 32'(tt4[i].y));
        end

        // WIDTH=8 random against an arithmetic model, registered copy one cycle later.
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            c8 = 1'($urandom_range(0, 1));
            model = {1'b0, a8} - {1'b0, b8} - {8'h0, c8};
            #1;
            chk($sformatf("rnd_comb[%0d]", n), 32'({y8, x8}), 32'(model));
            model_prev = model;
            @(posedge clk); #1;
            chk($sformatf("rnd_reg[%0d]", n), 32'({yq8, xq8}), 32'(model_prev));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
